// File: rtl/alu_result_fifo.sv
// First-word-fall-through buffer for ALU results and Z/N/C/V flags, with a sticky flag OR.
// Define ALU_RESULT_FIFO_STATS_EN to add saturating push/pop/stall counters.
module alu_result_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic [3:0]        sticky_flags,
`ifdef ALU_RESULT_FIFO_STATS_EN
  output logic [15:0]       stat_push,
  output logic [15:0]       stat_pop,
  output logic [15:0]       stat_stall,
`endif
  input  logic              sticky_clr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W+3:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W+3:0] head;
  logic              push;
  logic              pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head       = mem[rd_ptr];
  assign out_result = empty ? '0 : head[DATA_W+3:4];
  assign out_flags  = empty ? '0 : head[3:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_result, in_flags};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Clear takes effect before accumulating a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (sticky_clr) begin
      sticky_flags <= push ? in_flags : '0;
    end else if (push) begin
      sticky_flags <= sticky_flags | in_flags;
    end
  end

`ifdef ALU_RESULT_FIFO_STATS_EN
  logic stall;
  assign stall = in_valid && !in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_push  <= '0;
      stat_pop   <= '0;
      stat_stall <= '0;
    end else if (sticky_clr) begin
      stat_push  <= {15'd0, push};
      stat_pop   <= {15'd0, pop};
      stat_stall <= {15'd0, stall};
    end else begin
      if (push  && stat_push  != '1) stat_push  <= stat_push  + 16'd1;
      if (pop   && stat_pop   != '1) stat_pop   <= stat_pop   + 16'd1;
      if (stall && stat_stall != '1) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: directed stimulus, negedge monitor with occupancy model.
module tb_alu_result_fifo;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [3:0]        in_flags;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [3:0]        out_flags;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic [3:0]        sticky_flags;
  logic              sticky_clr;
`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [15:0]       stat_push;
  logic [15:0]       stat_pop;
  logic [15:0]       stat_stall;
`endif

  int vectors     = 0;
  int miscompares = 0;

  alu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .count(count), .full(full), .empty(empty), .sticky_flags(sticky_flags),
`ifdef ALU_RESULT_FIFO_STATS_EN
    .stat_push(stat_push), .stat_pop(stat_pop), .stat_stall(stat_stall),
`endif
    .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected entries in acceptance order, plus reference occupancy/sticky/stats.
  logic [DATA_W+3:0] sb[$];
  int        m_count  = 0;
  logic [3:0] m_sticky = '0;
  int        m_push = 0, m_pop = 0, m_stall = 0;

  function automatic int sat_inc(input int v, input bit ev, input bit clr);
    if (clr) return ev ? 1 : 0;
    if (ev && v < 16'hFFFF) return v + 1;
    return v;
  endfunction

  always @(negedge clk) begin
    bit mpush, mpop, mstall;
    if (rst) begin
      sb.delete();
      m_count = 0; m_sticky = '0; m_push = 0; m_pop = 0; m_stall = 0;
    end else begin
      check("count",     64'(count),     64'(m_count));
      check("full",      64'(full),      64'(m_count == DEPTH));
      check("empty",     64'(empty),     64'(m_count == 0));
      check("in_ready",  64'(in_ready),  64'(m_count != DEPTH));
      check("out_valid", 64'(out_valid), 64'(m_count != 0));
      check("sticky",    64'(sticky_flags), 64'(m_sticky));
      if (m_count != 0) begin
        check("head_result", 64'(out_result), 64'(sb[0][DATA_W+3:4]));
        check("head_flags",  64'(out_flags),  64'(sb[0][3:0]));
      end else begin
        check("empty_result", 64'(out_result), 64'd0);
        check("empty_flags",  64'(out_flags),  64'd0);
      end
`ifdef ALU_RESULT_FIFO_STATS_EN
      check("stat_push",  64'(stat_push),  64'(m_push));
      check("stat_pop",   64'(stat_pop),   64'(m_pop));
      check("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
      mpush  = in_valid && (m_count < DEPTH);
      mpop   = out_ready && (m_count > 0);
      mstall = in_valid && (m_count == DEPTH);
      if (mpop) void'(sb.pop_front());
      if (mpush) sb.push_back({in_result, in_flags});
      m_count = m_count + int'(mpush) - int'(mpop);
      if (sticky_clr) m_sticky = mpush ? in_flags : 4'b0000;
      else if (mpush) m_sticky = m_sticky | in_flags;
      m_push  = sat_inc(m_push,  mpush,  sticky_clr);
      m_pop   = sat_inc(m_pop,   mpop,   sticky_clr);
      m_stall = sat_inc(m_stall, mstall, sticky_clr);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_one(input logic [DATA_W-1:0] d, input logic [3:0] f);
    in_valid = 1'b1; in_result = d; in_flags = f;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0;
    out_ready = 1'b0; sticky_clr = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc();
    check("rst_count",  64'(count),        64'd0);
    check("rst_empty",  64'(empty),        64'd1);
    check("rst_ready",  64'(in_ready),     64'd1);
    check("rst_valid",  64'(out_valid),    64'd0);
    check("rst_result", 64'(out_result),   64'd0);
    check("rst_sticky", 64'(sticky_flags), 64'd0);

    // Three pushes held at the head, then drained in order.
    push_one(32'h11, 4'b0010);
    push_one(32'h22, 4'b0000);
    push_one(32'h33, 4'b0010);
    cyc(2);
    check("hold_count",  64'(count),      64'd3);
    check("hold_result", 64'(out_result), 64'h11);
    out_ready = 1'b1;
    cyc(3);
    out_ready = 1'b0;
    check("drain_empty", 64'(empty), 64'd1);

    // Fill, stall, pop one, then the stalled word enters.
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    for (int i = 0; i < DEPTH; i++) push_one(32'h100 + 32'(i), 4'b0000);
    check("fill_full",  64'(full),     64'd1);
    check("fill_ready", 64'(in_ready), 64'd0);
    check("fill_count", 64'(count),    64'd8);
    in_valid = 1'b1; in_result = 32'h108; in_flags = 4'b0100;
    cyc(5);
    check("stall_count", 64'(count), 64'd8);
`ifdef ALU_RESULT_FIFO_STATS_EN
    check("stall_stat", 64'(stat_stall), 64'd5);
`endif
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("freed_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    check("refill_count", 64'(count), 64'd8);
    out_ready = 1'b1;
    cyc(8);
    out_ready = 1'b0;
    check("wrap_empty", 64'(empty), 64'd1);

    // Concurrent push/pop at steady occupancy 4.
    for (int i = 0; i < 4; i++) push_one(32'h200 + 32'(i), 4'b0001);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 4; i < 14; i++) begin
      in_result = 32'h200 + 32'(i);
      cyc();
      check("steady_count", 64'(count), 64'd4);
    end
    in_valid = 1'b0;
    cyc(4);
    out_ready = 1'b0;

    // Sticky accumulate / clear behaviour.
    sticky_clr = 1'b1; cyc(); sticky_clr = 1'b0;
    check("sticky_clr0", 64'(sticky_flags), 64'd0);
    push_one(32'h300, 4'b0001);
    push_one(32'h301, 4'b1000);
    check("sticky_or", 64'(sticky_flags), 64'b1001);
    sticky_clr = 1'b1;
    push_one(32'h302, 4'b0100);
    sticky_clr = 1'b0;
    check("sticky_clr_push", 64'(sticky_flags), 64'b0100);
`ifdef ALU_RESULT_FIFO_STATS_EN
    check("stat_push_clr", 64'(stat_push), 64'd1);
`endif
    sticky_clr = 1'b1; cyc(); sticky_clr = 1'b0;
    check("sticky_clr1", 64'(sticky_flags), 64'd0);
    out_ready = 1'b1; cyc(3); out_ready = 1'b0;

    // Asynchronous reset with five entries queued.
    for (int i = 0; i < 5; i++) push_one(32'h400 + 32'(i), 4'b0011);
    check("pre_rst_count", 64'(count), 64'd5);
    #2 rst = 1'b1;
    #1;
    check("async_count",  64'(count),      64'd0);
    check("async_valid",  64'(out_valid),  64'd0);
    check("async_result", 64'(out_result), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    push_one(32'h5A5, 4'b0110);
    check("post_rst_result", 64'(out_result), 64'h5A5);
    check("post_rst_flags",  64'(out_flags),  64'b0110);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach end of stimulus");
    $fatal(1);
  end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Result buffer directly downstream of the ALU.
- Captures each ALU result word and its Z/N/C/V flags through a valid/ready handshake.
- Holds up to DEPTH entries in first-word-fall-through order for the writeback/consumer stage.
- Keeps a sticky OR of all accepted flags for status/exception reporting.

Parameters:
DATA_W, 32, width of ALU result word
DEPTH, 8, number of entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  ALU presents a result
in_ready  output  1  buffer can accept (= !full)
in_result  input  DATA_W  ALU result word
in_flags  input  4  {Z,N,C,V} from ALU
out_valid  output  1  head entry available (= !empty)
out_ready  input  1  consumer accepts head entry
out_result  output  DATA_W  head result; 0 when out_valid=0
out_flags  output  4  head flags; 0 when out_valid=0
count  output  CNT_W  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
sticky_flags  output  4  OR of flags of every accepted entry since last clear
sticky_clr  input  1  clear sticky_flags

Behaviour:
- Reset (async assert, sync release on clk):
  - wr_ptr=0, rd_ptr=0, count=0, sticky_flags=0.
  - Outputs: empty=1, full=0, in_ready=1, out_valid=0, out_result=0, out_flags=0.
- Storage:
  - DEPTH x (DATA_W+4) register array; contents not reset.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: in_valid && in_ready at a clk edge writes {in_result,in_flags} to mem[wr_ptr] and increments wr_ptr.
- Pop: out_valid && out_ready at a clk edge increments rd_ptr.
- Occupancy update per edge:
  - push only: count+1
  - pop only: count-1
  - both: count unchanged
  - neither: unchanged
- Latency: entry pushed at edge N shows out_valid=1 with its data after edge N. No combinational in->out bypass.
- Outputs out_result/out_flags are mem[rd_ptr] gated to 0 when empty. Head data stays stable while out_valid=1 and out_ready=0.
- Full: in_ready=0. in_valid held high is a stall, not a drop. A pop at a full edge frees a slot, so in_ready=1 on the following cycle. No same-cycle push-on-pop when full.
- Empty: out_valid=0. out_ready is ignored, and a pop never decrements count below 0.
- Handshake rules:
  - in_ready and out_valid depend only on registered state, never combinationally on in_valid/out_ready.
  - Upstream must hold in_result/in_flags stable while in_valid=1 and in_ready=0.
- Sticky flags:
  - On push: sticky_flags <= sticky_flags | in_flags.
  - sticky_clr alone: sticky_flags <= 0.
  - sticky_clr with push in the same cycle: sticky_flags <= in_flags (clear first, then accumulate).
- Reset mid-operation: all queued entries are discarded and state returns to reset values immediately on rst assertion.

Optional Feature:
- Macro: ALU_RESULT_FIFO_STATS_EN.
- Defined: adds three 16-bit outputs, each saturating at 16'hFFFF, reset to 0, and all cleared by sticky_clr:
  - stat_push: count of accepted pushes
  - stat_pop: count of accepted pops
  - stat_stall: count of cycles with in_valid=1 && in_ready=0
- A push, pop or stall in the same cycle as sticky_clr leaves that counter at 1.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle: count=0, empty=1, in_ready=1, out_valid=0, out_result=0, sticky_flags=0.
- Push 0x11,0x22,0x33 on consecutive cycles, out_ready=0: count=3, out_result=0x11 held stable. Then out_ready=1: 0x11,0x22,0x33 in order, then empty=1.
- Wrap-around: fill 8 entries (0x100..0x107) -> full=1, in_ready=0, count=8. Hold in_valid with 0x108: 5 stall cycles, no write, stat_stall=5 with STATS_EN. Pop one -> in_ready=1 next cycle, 0x108 accepted into slot 0. Drain order is 0x101..0x108.
- Simultaneous push/pop at count=4 for 10 cycles: count stays 4, output order preserved, no gaps.
- Sticky: push flags 4'b0001 then 4'b1000 -> sticky=4'b1001. sticky_clr together with a push of 4'b0100 -> sticky=4'b0100. sticky_clr alone -> 0.
- Assert rst with count=5 mid-stream: count=0, out_valid=0, out_result=0 immediately. A push after release is read back correctly.
